systolic_pe: RTL

Parametrised processing element for the systolic array, replacing the fixed 8-bit MAC cell. Each cell runs in one of two runtime-selectable modes:
- output-stationary (OS): accumulates locally and drains on command.
- weight-stationary (WS): holds a preloaded weight and adds its product to a partial sum flowing down the column.

The cell forwards operands to its east/south neighbours, accumulates with saturation, and reports sticky overflow. It is tiled `SIZE×SIZE` by the array top level.

---
 rtl/systolic_pkg.sv | 22 ++
 rtl/systolic_mac.sv | 39 +++
 rtl/systolic_pe.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared types and constants for the systolic array cells
package systolic_pkg;

    localparam int data_width_c = 8;
    localparam int acc_width_c  = 24;

    typedef logic [data_width_c-1:0] t_mac_data;
    typedef logic [acc_width_c-1:0]  t_mac_acc;

    typedef enum logic {
        PE_OS = 1'b0,
        PE_WS = 1'b1
    } t_pe_mode;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        WREADY = 2'd2,
        DRAIN  = 2'd3
    } t_pe_state;

endpackage

// File: rtl/systolic_mac.sv
// rtl/systolic_mac.sv - combinational signed multiply with saturating/wrapping add
module systolic_mac #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int SATURATE   = 1
) (
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic [ACC_WIDTH-1:0]  addend_i,
    output logic [ACC_WIDTH-1:0]  sum_o,
    output logic                  ovf_o
);

    localparam int PW = 2 * DATA_WIDTH;

    logic signed [PW-1:0]      prod;
    logic signed [ACC_WIDTH:0] wide;

    assign prod = $signed(a_i) * $signed(b_i);

    // One guard bit above the accumulator width exposes signed overflow.
    assign wide = $signed({addend_i[ACC_WIDTH-1], addend_i})
                + $signed({{(ACC_WIDTH + 1 - PW){prod[PW-1]}}, prod});

    assign ovf_o = wide[ACC_WIDTH] ^ wide[ACC_WIDTH-1];

    // Clamp toward the sign of the true result, or pass the wrapped bits through.
    always_comb begin
        sum_o = wide[ACC_WIDTH-1:0];
        if ((SATURATE != 0) && ovf_o) begin
            if (wide[ACC_WIDTH]) begin
                sum_o = {1'b1, {(ACC_WIDTH-1){1'b0}}};
            end else begin
                sum_o = {1'b0, {(ACC_WIDTH-1){1'b1}}};
            end
        end
    end

endmodule

// File: rtl/systolic_pe.sv
// rtl/systolic_pe.sv - dual-mode (output/weight stationary) systolic processing element
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = data_width_c,
    parameter int ACC_WIDTH  = acc_width_c,
    parameter int SATURATE   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic                  a_valid_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic                  b_valid_i,
    input  logic                  load_w_i,
    input  logic [ACC_WIDTH-1:0]  psum_i,
    input  logic                  psum_valid_i,
    input  logic                  clear_i,
    input  logic                  drain_i,
    output logic [DATA_WIDTH-1:0] a_o,
    output logic                  a_valid_o,
    output logic [DATA_WIDTH-1:0] b_o,
    output logic                  b_valid_o,
    output logic [ACC_WIDTH-1:0]  acc_o,
    output logic                  acc_valid_o,
    output logic                  ovf_o,
    output logic                  busy_o
);

    t_pe_state             state_q, state_d;
    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [DATA_WIDTH-1:0] w_q, w_d;
    logic                  ovf_q, ovf_d;
    logic                  tile_q, tile_d;
    logic [ACC_WIDTH-1:0]  acc_out_q, acc_out_d;
    logic                  acc_valid_q, acc_valid_d;

    logic [DATA_WIDTH-1:0] a_fwd_q, b_fwd_q;
    logic                  a_fwd_valid_q, b_fwd_valid_q;

    logic [DATA_WIDTH-1:0] mac_b;
    logic [ACC_WIDTH-1:0]  mac_addend;
    logic [ACC_WIDTH-1:0]  mac_sum;
    logic                  mac_ovf;
    logic                  pair;
    t_pe_mode              mode_sel;

    assign pair     = a_valid_i & b_valid_i;
    assign mode_sel = t_pe_mode'(mode_i);

    // Operand select: WS multiplies by the held weight, the OS paths by the north operand.
    always_comb begin
        mac_b      = b_i;
        mac_addend = '0;
        unique case (state_q)
            ACCUM:   mac_addend = drain_i ? '0 : acc_q;
            DRAIN:   mac_addend = acc_q;
            WREADY: begin
                mac_b      = w_q;
                mac_addend = psum_valid_i ? psum_i : '0;
            end
            default: mac_addend = '0;
        endcase
    end

    systolic_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH),
        .SATURATE   (SATURATE)
    ) u_mac (
        .a_i      (a_i),
        .b_i      (mac_b),
        .addend_i (mac_addend),
        .sum_o    (mac_sum),
        .ovf_o    (mac_ovf)
    );

    // Next-state and datapath updates; clear beats drain beats accumulate/load.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        w_d         = w_q;
        ovf_d       = ovf_q;
        tile_d      = tile_q;
        acc_out_d   = acc_out_q;
        acc_valid_d = 1'b0;

        if (clear_i) begin
            state_d = IDLE;
            acc_d   = '0;
            w_d     = '0;
            ovf_d   = 1'b0;
            tile_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (mode_sel == PE_OS && pair) begin
                        acc_d   = mac_sum;
                        state_d = ACCUM;
                    end else if (mode_sel == PE_WS && b_valid_i && load_w_i) begin
                        w_d     = b_i;
                        state_d = WREADY;
                    end
                end
                ACCUM: begin
                    if (drain_i) begin
                        // Result leaves now; a concurrent pair opens the next tile.
                        acc_out_d   = acc_q;
                        acc_valid_d = 1'b1;
                        acc_d       = pair ? mac_sum : '0;
                        tile_d      = pair;
                        state_d     = DRAIN;
                    end else if (pair) begin
                        acc_d = mac_sum;
                        ovf_d = ovf_q | mac_ovf;
                    end
                end
                DRAIN: begin
                    // Overflow of the drained tile stays visible alongside its result.
                    if (pair) begin
                        acc_d = mac_sum;
                        ovf_d = mac_ovf;
                    end else begin
                        ovf_d = 1'b0;
                    end
                    tile_d  = 1'b0;
                    state_d = (pair || tile_q) ? ACCUM : IDLE;
                end
                WREADY: begin
                    if (a_valid_i) begin
                        acc_out_d   = mac_sum;
                        acc_valid_d = 1'b1;
                        ovf_d       = ovf_q | mac_ovf;
                    end
                    if (b_valid_i && load_w_i) begin
                        w_d = b_i;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Control and accumulator state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            w_q         <= '0;
            ovf_q       <= 1'b0;
            tile_q      <= 1'b0;
            acc_out_q   <= '0;
            acc_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            w_q         <= w_d;
            ovf_q       <= ovf_d;
            tile_q      <= tile_d;
            acc_out_q   <= acc_out_d;
            acc_valid_q <= acc_valid_d;
        end
    end

    // Operand forwarding to east/south neighbours, active in every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_fwd_q       <= '0;
            a_fwd_valid_q <= 1'b0;
            b_fwd_q       <= '0;
            b_fwd_valid_q <= 1'b0;
        end else begin
            a_fwd_q       <= a_i;
            a_fwd_valid_q <= a_valid_i;
            b_fwd_q       <= b_i;
            b_fwd_valid_q <= b_valid_i;
        end
    end

    assign a_o         = a_fwd_q;
    assign a_valid_o   = a_fwd_valid_q;
    assign b_o         = b_fwd_q;
    assign b_valid_o   = b_fwd_valid_q;
    assign acc_o       = acc_out_q;
    assign acc_valid_o = acc_valid_q;
    assign ovf_o       = ovf_q;
    assign busy_o      = (state_q != IDLE);

endmodule
